// File: rtl/gctr_decrypt.sv
// gctr_decrypt: streaming 64-bit GCTR decryptor fed by an external block-cipher keystream port
module gctr_decrypt #(
  parameter logic [63:0] ICB_INIT = 64'hABAC8CA6000AA98A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        use_icb_in,
  input  logic [63:0] icb_in,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [6:0]  in_nbits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [6:0]  out_nbits,
  output logic        ciph_req,
  output logic [63:0] ciph_block,
  input  logic        ciph_ack,
  input  logic [63:0] ciph_result
);
  typedef enum logic [1:0] {IDLE, KS_REQ, DATA} state_t;
  state_t      state_q, state_d;
  logic [63:0] ctr_q, ctr_d, ks_q, ks_d, out_data_q, out_data_d, mask;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d, in_fire;
  logic [6:0]  out_nbits_q, out_nbits_d, n;
  always_comb begin
    n = (in_last && in_nbits >= 7'd1 && in_nbits <= 7'd64) ? in_nbits : 7'd64;
    mask = ~({64{1'b1}} >> n);
    in_fire = in_valid && in_ready;
    state_d = state_q;
    ctr_d = ctr_q;
    ks_d = ks_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_nbits_d = out_nbits_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d = (in_data ^ ks_q) & mask;
      out_last_d = in_last;
      out_nbits_d = n;
    end
    case (state_q)
      IDLE: if (start) begin
        ctr_d = use_icb_in ? icb_in : ICB_INIT;
        state_d = KS_REQ;
      end
      KS_REQ: if (ciph_ack) begin
        ks_d = ciph_result;
        ctr_d = {ctr_q[63:32], ctr_q[31:0] + 32'd1};
        state_d = DATA;
      end
      DATA: if (in_fire) state_d = in_last ? IDLE : KS_REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q <= ICB_INIT;
      ks_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_nbits_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      ks_q <= ks_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_nbits_q <= out_nbits_d;
    end
  end
  // ack only matters in KS_REQ, so late acks outside a request fall through
  assign ciph_req = state_q == KS_REQ;
  assign ciph_block = ciph_req ? ctr_q : '0;
  assign in_ready = state_q == DATA && (!out_valid_q || out_ready);
  assign busy = state_q != IDLE || out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_nbits = out_nbits_q;
endmodule

// File: tb/tb_gctr_decrypt.sv
// tb_gctr_decrypt: directed scenarios against a 3-cycle inverting cipher model
module tb_gctr_decrypt;
  logic        clk = 0, reset = 1, start = 0, use_icb_in = 0;
  logic [63:0] icb_in = '0, in_data = '0, ciph_result = '0;
  logic        in_valid = 0, in_last = 0, out_ready = 1, ciph_ack = 0;
  logic [6:0]  in_nbits = '0;
  logic        busy, in_ready, out_valid, out_last, ciph_req;
  logic [63:0] out_data, ciph_block;
  logic [6:0]  out_nbits;
  int          total = 0, bad = 0;
  bit          model_en = 1;
  int          cnt = 0, nblk = 0;
  logic [63:0] blk_log [8];

  gctr_decrypt dut (
    .clk(clk), .reset(reset), .start(start), .use_icb_in(use_icb_in), .icb_in(icb_in),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbits(in_nbits), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_nbits(out_nbits), .ciph_req(ciph_req),
    .ciph_block(ciph_block), .ciph_ack(ciph_ack), .ciph_result(ciph_result)
  );

  always #5 clk = ~clk;

  // cipher model: result = ~block, acked on the third cycle of a request
  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
      if (model_en) ciph_ack = 0;
    end else if (model_en) begin
      if (ciph_ack) begin
        ciph_ack = 0;
        cnt = 0;
      end else if (ciph_req) begin
        cnt++;
        if (cnt == 3) begin
          ciph_ack = 1;
          ciph_result = ~ciph_block;
          if (nblk < 8) blk_log[nblk] = ciph_block;
          nblk++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic use_icb, input logic [63:0] icb);
    @(negedge clk);
    start = 1; use_icb_in = use_icb; icb_in = icb;
    @(posedge clk); #1;
    start = 0; use_icb_in = 0;
  endtask

  task automatic send(input logic [63:0] d, input logic l, input logic [6:0] nb);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1; in_data = d; in_last = l; in_nbits = nb;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_last, out_nbits, out_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%0b last=%0b nbits=%0d data=%h, required all 0", out_valid, out_last, out_nbits, out_data);
    end
    total++;
    if ({ciph_req, ciph_block, in_ready, busy} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: req=%0b block=%h in_ready=%0b busy=%0b, required all 0", ciph_req, ciph_block, in_ready, busy);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_message;
    logic [63:0] exp_blk [3];
    logic [63:0] exp_out [3];
    exp_blk = '{64'hABAC8CA6000AA98A, 64'hABAC8CA6000AA98B, 64'hABAC8CA6000AA98C};
    exp_out = '{64'h54537359FFF55675, 64'h54537359FFF55674, 64'h5440000000000000};
    nblk = 0;
    pulse_start(0, '0);
    for (int i = 0; i < 3; i++) begin
      send('0, i == 2, i == 2 ? 7'd11 : 7'd64);
      total++;
      if (out_valid !== 1 || out_data !== exp_out[i] || out_last !== (i == 2) || out_nbits !== (i == 2 ? 7'd11 : 7'd64)) begin
        bad++;
        $display("FAIL msg_out%0d: valid=%0b data=%h last=%0b nbits=%0d, required 1 %h %0b %0d", i, out_valid, out_data, out_last, out_nbits, exp_out[i], i == 2, i == 2 ? 11 : 64);
      end
      total++;
      if (blk_log[i] !== exp_blk[i]) begin
        bad++;
        $display("FAIL msg_blk%0d: ciph_block=%h, required %h", i, blk_log[i], exp_blk[i]);
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 0 || out_valid !== 0 || ciph_req !== 0) begin
      bad++;
      $display("FAIL msg_idle: busy=%0b out_valid=%0b req=%0b, required 0 0 0", busy, out_valid, ciph_req);
    end
  endtask

  task automatic test_icb_wrap;
    nblk = 0;
    pulse_start(1, 64'h12345678FFFFFFFF);
    send('0, 0, 7'd64);
    total++;
    if (out_data !== 64'hEDCBA98700000000) begin
      bad++;
      $display("FAIL icb_out0: data=%h, required edcba98700000000", out_data);
    end
    send('0, 1, 7'd64);
    total++;
    if (blk_log[1] !== 64'h1234567800000000) begin
      bad++;
      $display("FAIL icb_wrap_blk: ciph_block=%h, required 1234567800000000", blk_log[1]);
    end
    total++;
    if (out_data !== 64'hEDCBA987FFFFFFFF || out_last !== 1) begin
      bad++;
      $display("FAIL icb_out1: data=%h last=%0b, required edcba987ffffffff 1", out_data, out_last);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int stall_bad;
    stall_bad = 0;
    out_ready = 0;
    pulse_start(0, '0);
    send(64'hFFFF0000FFFF0000, 0, 7'd64);
    total++;
    if (out_valid !== 1 || out_data !== 64'hABAC7359000A5675) begin
      bad++;
      $display("FAIL bp_first: valid=%0b data=%h, required 1 abac7359000a5675", out_valid, out_data);
    end
    repeat (6) @(negedge clk);
    in_valid = 1; in_data = '0; in_last = 1; in_nbits = 7'd64;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1 || in_ready !== 0 || out_data !== 64'hABAC7359000A5675) stall_bad++;
      @(negedge clk);
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stall: %0d stalled cycles wrong (valid=%0b in_ready=%0b data=%h), required 0", stall_bad, out_valid, in_ready, out_data);
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1) begin
      bad++;
      $display("FAIL bp_release_ready: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    total++;
    if (out_valid !== 1 || out_data !== 64'h54537359FFF55674 || out_last !== 1) begin
      bad++;
      $display("FAIL bp_reload: valid=%0b data=%h last=%0b, required 1 54537359fff55674 1", out_valid, out_data, out_last);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    pulse_start(0, '0);
    send(64'h0123456789ABCDEF, 0, 7'd64);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 0 || out_data !== '0 || out_nbits !== '0 || busy !== 0) begin
      bad++;
      $display("FAIL rst_data: valid=%0b data=%h nbits=%0d busy=%0b, required 0", out_valid, out_data, out_nbits, busy);
    end
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    model_en = 0;
    pulse_start(1, 64'h0000000100000005);
    @(negedge clk);
    total++;
    if (ciph_req !== 1 || ciph_block !== 64'h0000000100000005) begin
      bad++;
      $display("FAIL rst_ksreq_pre: req=%0b block=%h, required 1 0000000100000005", ciph_req, ciph_block);
    end
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    ciph_ack = 1; ciph_result = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    ciph_ack = 0;
    @(negedge clk);
    total++;
    if ({ciph_req, ciph_block, busy, in_ready, out_valid, out_data} !== '0) begin
      bad++;
      $display("FAIL rst_late_ack: req=%0b block=%h busy=%0b in_ready=%0b valid=%0b data=%h, required all 0", ciph_req, ciph_block, busy, in_ready, out_valid, out_data);
    end
    cnt = 0;
    model_en = 1;
  endtask

  task automatic test_nbits_and_start;
    nblk = 0;
    pulse_start(0, '0);
    pulse_start(1, '0);
    send('0, 1, 7'd0);
    total++;
    if (blk_log[0] !== 64'hABAC8CA6000AA98A) begin
      bad++;
      $display("FAIL busy_start: ciph_block=%h, required abac8ca6000aa98a", blk_log[0]);
    end
    total++;
    if (out_data !== 64'h54537359FFF55675 || out_nbits !== 7'd64) begin
      bad++;
      $display("FAIL nbits0: data=%h nbits=%0d, required 54537359fff55675 64", out_data, out_nbits);
    end
    pulse_start(0, '0);
    send('0, 1, 7'd100);
    total++;
    if (out_data !== 64'h54537359FFF55675 || out_nbits !== 7'd64) begin
      bad++;
      $display("FAIL nbits100: data=%h nbits=%0d, required 54537359fff55675 64", out_data, out_nbits);
    end
    pulse_start(0, '0);
    send('1, 1, 7'd1);
    total++;
    if (out_data !== 64'h8000000000000000 || out_nbits !== 7'd1) begin
      bad++;
      $display("FAIL nbits1: data=%h nbits=%0d, required 8000000000000000 1", out_data, out_nbits);
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 0) begin
      bad++;
      $display("FAIL final_idle: busy=%0b, required 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_message;
    test_icb_wrap;
    test_back_to_back;
    test_reset_mid;
    test_nbits_and_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
